// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding the FD register through an output slot
// and a one-entry skid buffer; supports redirect flushes and a terminal halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_done,
  output logic [15:0] instr,
  output logic [15:0] pc_inc,
  output logic        valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_HALTED} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d;
  logic [15:0] instr_q, instr_d, pc_inc_q, pc_inc_d;
  logic [15:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
  logic        valid_q, valid_d, skid_q, skid_d, halt_q, halt_d;
  logic        consume, slot_free, issue, flush, load, halt_now, busy;
  logic [15:0] pc_next;
  assign pc_next   = pc_q + 16'd2;
  assign consume   = valid_q && !stall;
  assign slot_free = !skid_q && (!valid_q || !stall);
  assign issue     = state_q == S_REQ && slot_free && !redirect && !halt;
  assign flush     = redirect && state_q != S_HALTED;
  assign load      = mem_done && state_q == S_WAIT && !redirect;
  assign halt_now  = halt && !redirect;
  assign busy      = state_q == S_WAIT || state_q == S_DISCARD;
  // Gating with rst keeps the request low while reset is held, since REQ is the reset state
  assign mem_rd    = rst && (issue || busy);
  assign mem_addr  = state_q == S_REQ ? pc_q : addr_q;
  assign instr     = instr_q;
  assign pc_inc    = pc_inc_q;
  assign valid     = valid_q;
  always_comb begin
    case (state_q)
      S_REQ:     state_d = redirect ? S_REQ : halt ? S_HALTED : issue ? S_WAIT : S_REQ;
      S_WAIT:    state_d = !mem_done ? (redirect ? S_DISCARD : S_WAIT)
                                     : (!redirect && (halt_q || halt)) ? S_HALTED : S_REQ;
      S_DISCARD: state_d = !mem_done ? S_DISCARD : (halt_q || halt_now) ? S_HALTED : S_REQ;
      default:   state_d = S_HALTED;
    endcase
    pc_d   = flush ? redirect_pc : load ? pc_next : pc_q;
    addr_d = issue ? pc_q : addr_q;
    halt_d = halt_q || (halt_now && busy);
  end
  // Output slot refills from the skid entry first so program order is preserved
  always_comb begin
    instr_d      = instr_q;
    pc_inc_d     = pc_inc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_d       = skid_q;
    if (flush) begin
      valid_d = 1'b0;
      skid_d  = 1'b0;
    end else if (consume) begin
      valid_d      = skid_q || load;
      instr_d      = skid_q ? skid_instr_q : load ? mem_data : instr_q;
      pc_inc_d     = skid_q ? skid_pc_q : load ? pc_next : pc_inc_q;
      skid_d       = skid_q && load;
      skid_instr_d = load ? mem_data : skid_instr_q;
      skid_pc_d    = load ? pc_next : skid_pc_q;
    end else if (load) begin
      valid_d      = 1'b1;
      instr_d      = valid_q ? instr_q : mem_data;
      pc_inc_d     = valid_q ? pc_inc_q : pc_next;
      skid_d       = valid_q;
      skid_instr_d = valid_q ? mem_data : skid_instr_q;
      skid_pc_d    = valid_q ? pc_next : skid_pc_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      instr_q      <= 16'h0000;
      pc_inc_q     <= 16'h0000;
      valid_q      <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc_q    <= 16'h0000;
      skid_q       <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      pc_inc_q     <= pc_inc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_q       <= skid_d;
      halt_q       <= halt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against an
// architectural model (instructions must arrive as mem[pc], mem[pc+2], ... restarting at each redirect).
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic [15:0] mem_addr, mem_data = 16'h0000, instr, pc_inc, redirect_pc = 16'h0000;
  logic        mem_rd, mem_done = 1'b0, valid, stall = 1'b0, redirect = 1'b0, halt = 1'b0;
  int          n_chk = 0, n_fail = 0;
  bit          busy, xfer, obs_busy;
  int          cnt;
  logic [15:0] raddr, resp, x_instr, x_pcinc, obs_raddr;
  logic [15:0] dq[$];
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(16'hFFFE)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_done(mem_done), .instr(instr), .pc_inc(pc_inc), .valid(valid), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );
  function automatic logic [15:0] word(input logic [15:0] a);
    return (a * 16'd13) ^ 16'h5A3C;
  endfunction
  // memory side: latency lat counts cycles from the request cycle to the mem_done cycle
  task automatic observe(input int lat);
    xfer = valid && !stall;
    x_instr = instr;
    x_pcinc = pc_inc;
    obs_busy = busy;
    obs_raddr = raddr;
    if (busy && mem_done) busy = 0;
    else if (!busy && mem_rd) begin
      busy = 1;
      cnt = lat;
      raddr = mem_addr;
      resp = dq.size() > 0 ? dq.pop_front() : word(mem_addr);
    end
  endtask
  task automatic cyc(input int lat, input bit st, input bit rd, input logic [15:0] rp, input bit hl);
    @(posedge clk);
    #2;
    stall = st; redirect = rd; redirect_pc = rp; halt = hl;
    mem_done = 0;
    mem_data = 16'($urandom);
    if (busy) begin
      cnt--;
      if (cnt == 0) begin mem_done = 1; mem_data = resp; end
    end
    #1;
    observe(lat);
  endtask
  task automatic do_reset(input int lat, input bit rd, input logic [15:0] rp, input bit hl);
    rst = 0; mem_done = 0; stall = 0; redirect = 0; halt = 0; busy = 0;
    repeat (2) @(posedge clk);
    #2;
    redirect = rd; redirect_pc = rp; halt = hl;
    rst = 1;
    #1;
    observe(lat);
  endtask
  task automatic test_reset();
    @(posedge clk);
    #3;
    n_chk += 4;
    if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    if (pc_inc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc_inc: got %h expected 0000", pc_inc); end
    do_reset(1, 0, 16'h0000, 0);
    n_chk += 2;
    if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", mem_rd); end
    if (mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL first_addr: got %h expected fffe", mem_addr); end
  endtask
  task automatic test_wrap();
    dq = {16'h1111, 16'h2222};
    do_reset(1, 0, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFE}) begin n_fail++; $display("FAIL wrap_hold: got %b/%h expected 1/fffe", mem_rd, mem_addr); end
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk += 3;
    if ({xfer, x_instr} !== {1'b1, 16'h1111}) begin n_fail++; $display("FAIL wrap_instr1: got %b/%h expected 1/1111", xfer, x_instr); end
    if (x_pcinc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pcinc1: got %h expected 0000", x_pcinc); end
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL wrap_addr2: got %b/%h expected 1/0000", mem_rd, mem_addr); end
    cyc(1, 0, 0, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk += 2;
    if ({xfer, x_instr} !== {1'b1, 16'h2222}) begin n_fail++; $display("FAIL wrap_instr2: got %b/%h expected 1/2222", xfer, x_instr); end
    if (x_pcinc !== 16'h0002) begin n_fail++; $display("FAIL wrap_pcinc2: got %h expected 0002", x_pcinc); end
  endtask
  task automatic test_zero_wait();
    logic [15:0] gi[$], gp[$];
    int gc[$];
    dq = {16'hA001, 16'hA002};
    do_reset(1, 1, 16'h0000, 0);
    n_chk++;
    if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL zw_redirect_noissue: got %b expected 0", mem_rd); end
    for (int k = 0; k < 12; k++) begin
      cyc(1, 0, 0, 16'h0000, 0);
      if (xfer && gi.size() < 2) begin gi.push_back(x_instr); gp.push_back(x_pcinc); gc.push_back(k); end
    end
    n_chk++;
    if (gi.size() != 2) begin n_fail++; $display("FAIL zw_count: got %0d expected 2", gi.size()); end
    else begin
      n_chk += 3;
      if ({gi[0], gp[0]} !== {16'hA001, 16'h0002}) begin n_fail++; $display("FAIL zw_first: got %h/%h expected a001/0002", gi[0], gp[0]); end
      if ({gi[1], gp[1]} !== {16'hA002, 16'h0004}) begin n_fail++; $display("FAIL zw_second: got %h/%h expected a002/0004", gi[1], gp[1]); end
      if (gc[0] != 2 || gc[1] != 4) begin n_fail++; $display("FAIL zw_latency: got cycles %0d,%0d expected 2,4", gc[0], gc[1]); end
    end
  endtask
  task automatic test_stall();
    logic [15:0] gi[$], gp[$];
    int gc[$];
    dq = {16'hB001, 16'hB002};
    do_reset(1, 0, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 16'h0000, 0);
      n_chk++;
      if ({valid, instr, mem_rd} !== {1'b1, 16'hB001, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b i=%h rd=%b expected v=1 i=b001 rd=0", k, valid, instr, mem_rd);
      end
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1, 0, 0, 16'h0000, 0);
      if (xfer && gi.size() < 2) begin gi.push_back(x_instr); gp.push_back(x_pcinc); gc.push_back(k); end
    end
    n_chk++;
    if (gi.size() != 2) begin n_fail++; $display("FAIL stall_count: got %0d expected 2", gi.size()); end
    else begin
      n_chk += 3;
      if ({gi[0], gp[0]} !== {16'hB001, 16'h0000}) begin n_fail++; $display("FAIL stall_first: got %h/%h expected b001/0000", gi[0], gp[0]); end
      if ({gi[1], gp[1]} !== {16'hB002, 16'h0002}) begin n_fail++; $display("FAIL stall_second: got %h/%h expected b002/0002", gi[1], gp[1]); end
      if (gc[0] != 0) begin n_fail++; $display("FAIL stall_release: got cycle %0d expected 0", gc[0]); end
    end
  endtask
  task automatic test_redirect();
    logic [15:0] gi[$], gp[$];
    dq = {16'hDEAD};
    do_reset(3, 0, 16'h0000, 0);
    cyc(1, 0, 1, 16'h0100, 0);
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk++;
    if ({mem_rd, mem_addr, valid} !== {1'b1, 16'hFFFE, 1'b0}) begin
      n_fail++; $display("FAIL redir_discard: got rd=%b a=%h v=%b expected rd=1 a=fffe v=0", mem_rd, mem_addr, valid);
    end
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk++;
    if ({mem_done, valid} !== 2'b10) begin n_fail++; $display("FAIL redir_done: got done=%b v=%b expected done=1 v=0", mem_done, valid); end
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk++;
    if ({mem_rd, mem_addr, valid} !== {1'b1, 16'h0100, 1'b0}) begin
      n_fail++; $display("FAIL redir_next: got rd=%b a=%h v=%b expected rd=1 a=0100 v=0", mem_rd, mem_addr, valid);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 16'h0000, 0);
      if (xfer) begin gi.push_back(x_instr); gp.push_back(x_pcinc); end
    end
    n_chk++;
    if (gi.size() == 0) begin n_fail++; $display("FAIL redir_count: got 0 expected >0"); end
    else begin
      n_chk++;
      if ({gi[0], gp[0]} !== {word(16'h0100), 16'h0102}) begin
        n_fail++; $display("FAIL redir_first: got %h/%h expected %h/0102", gi[0], gp[0], word(16'h0100));
      end
      foreach (gi[j]) begin
        n_chk++;
        if (gi[j] === 16'hDEAD) begin n_fail++; $display("FAIL redir_dead: got dead expected not dead"); end
      end
    end
  endtask
  task automatic test_redirect_halt();
    logic [15:0] gi[$], gp[$];
    do_reset(1, 1, 16'h0200, 1);
    n_chk++;
    if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rh_noissue: got %b expected 0", mem_rd); end
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0200}) begin n_fail++; $display("FAIL rh_addr: got %b/%h expected 1/0200", mem_rd, mem_addr); end
    for (int k = 0; k < 12; k++) begin
      cyc(1, 0, 0, 16'h0000, 0);
      if (xfer && gi.size() < 2) begin gi.push_back(x_instr); gp.push_back(x_pcinc); end
    end
    n_chk++;
    if (gi.size() != 2) begin n_fail++; $display("FAIL rh_count: got %0d expected 2", gi.size()); end
    else begin
      n_chk += 2;
      if ({gi[0], gp[0]} !== {word(16'h0200), 16'h0202}) begin n_fail++; $display("FAIL rh_first: got %h/%h expected %h/0202", gi[0], gp[0], word(16'h0200)); end
      if ({gi[1], gp[1]} !== {word(16'h0202), 16'h0204}) begin n_fail++; $display("FAIL rh_second: got %h/%h expected %h/0204", gi[1], gp[1], word(16'h0202)); end
    end
  endtask
  task automatic test_halt();
    do_reset(2, 0, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 1);
    cyc(1, 0, 0, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 0);
    n_chk += 2;
    if ({xfer, x_instr, x_pcinc} !== {1'b1, word(16'hFFFE), 16'h0000}) begin
      n_fail++; $display("FAIL halt_kept: got %b/%h/%h expected 1/%h/0000", xfer, x_instr, x_pcinc, word(16'hFFFE));
    end
    if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_stop: got %b expected 0", mem_rd); end
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 1, 16'h0300, k[0]);
      n_chk++;
      if ({mem_rd, valid} !== 2'b00) begin n_fail++; $display("FAIL halted%0d: got rd=%b v=%b expected 0/0", k, mem_rd, valid); end
    end
  endtask
  task automatic test_async_reset();
    logic [15:0] gi[$], gp[$];
    do_reset(1, 0, 16'h0000, 0);
    cyc(4, 0, 0, 16'h0000, 0);
    cyc(4, 0, 0, 16'h0000, 0);
    cyc(4, 0, 0, 16'h0000, 0);
    #4;
    rst = 0;
    #1;
    n_chk += 2;
    if ({mem_rd, valid} !== 2'b00) begin n_fail++; $display("FAIL async_ctrl: got rd=%b v=%b expected 0/0", mem_rd, valid); end
    if ({instr, pc_inc} !== 32'h0) begin n_fail++; $display("FAIL async_data: got %h/%h expected 0000/0000", instr, pc_inc); end
    busy = 0;
    @(posedge clk);
    #2;
    mem_done = 1;
    mem_data = 16'hBEEF;
    do_reset(1, 0, 16'h0000, 0);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFE}) begin n_fail++; $display("FAIL async_restart: got %b/%h expected 1/fffe", mem_rd, mem_addr); end
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 0, 16'h0000, 0);
      if (xfer) begin gi.push_back(x_instr); gp.push_back(x_pcinc); end
    end
    n_chk++;
    if (gi.size() == 0) begin n_fail++; $display("FAIL async_count: got 0 expected >0"); end
    else begin
      n_chk++;
      if ({gi[0], gp[0]} !== {word(16'hFFFE), 16'h0000}) begin
        n_fail++; $display("FAIL async_first: got %h/%h expected %h/0000", gi[0], gp[0], word(16'hFFFE));
      end
    end
  endtask
  task automatic test_random();
    logic [15:0] exp_pc, rp, nxt;
    bit halted, st, rd, hl;
    int n_xfer;
    exp_pc = 16'hFFFE;
    halted = 0;
    n_xfer = 0;
    do_reset(2, 0, 16'h0000, 0);
    for (int i = 0; i < 3000; i++) begin
      st = $urandom_range(0, 9) < 3;
      rd = !halted && $urandom_range(0, 19) == 0;
      rp = 16'($urandom) & 16'hFFFE;
      hl = i > 2500 && !halted && $urandom_range(0, 49) == 0;
      cyc($urandom_range(1, 4), st, rd, rp, hl);
      if (hl && !rd) halted = 1;
      if (obs_busy) begin
        n_chk++;
        if ({mem_rd, mem_addr} !== {1'b1, obs_raddr}) begin
          n_fail++; $display("FAIL rnd_hold@%0d: got %b/%h expected 1/%h", i, mem_rd, mem_addr, obs_raddr);
        end
      end else if (halted) begin
        n_chk++;
        if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rnd_halted@%0d: got %b expected 0", i, mem_rd); end
      end
      if (xfer) begin
        nxt = exp_pc + 16'd2;
        n_xfer++;
        n_chk++;
        if ({x_instr, x_pcinc} !== {word(exp_pc), nxt}) begin
          n_fail++; $display("FAIL rnd_xfer@%0d: got %h/%h expected %h/%h", i, x_instr, x_pcinc, word(exp_pc), nxt);
        end
        exp_pc = nxt;
      end
      if (rd) exp_pc = rp;
    end
    n_chk++;
    if (n_xfer < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d transfers expected >=200", n_xfer); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_wrap();
    test_zero_wait();
    test_stall();
    test_redirect();
    test_redirect_halt();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
